regfile_wb_queue: RTL and testbench
===================================

# regfile_wb_queue

Writeback queue that sits on the write side of the register file. It accepts writeback requests from the ALU and load paths into a small circular FIFO, then drains them one per cycle onto the register file write port (RegWrite / write_reg / write_data). Two combinational bypass lookups return data still pending in the queue, so reads of the register file are never stale.

## Interface
- DEPTH, 4: queue entries; power of two, at least 2.
- DATA_W, 32: data width.
- ADDR_W, 5: register index width.

Ports (name, direction, width, meaning):
- clk, in, 1: clock; all state updates on the rising edge.
- rst, in, 1: reset, synchronous, active-low.
- flush, in, 1: discard all queued entries (synchronous).
- mem_valid / mem_reg / mem_data, in, 1 / ADDR_W / DATA_W: load-path writeback request.
- alu_valid / alu_reg / alu_data, in, 1 / ADDR_W / DATA_W: ALU-path writeback request.
- enq_ready, out, 1: both sources may enqueue this cycle.
- wb_reg_write, out, 1: drives register file RegWrite.
- wb_reg, out, ADDR_W: drives write_reg.
- wb_data, out, DATA_W: drives write_data.
- lk_reg_1, lk_reg_2, in, ADDR_W: bypass lookup indices (same as read_reg_1/2).
- lk_hit_1, lk_hit_2, out, 1: pending write exists for the index.
- lk_data_1, lk_data_2, out, DATA_W: youngest pending data for the index.

## Operation
- State: head/tail pointers (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH), per-entry valid/reg/data, registered wb stage.
- enq_ready = (count <= DEPTH-2), evaluated before the same-cycle dequeue. This is conservative: room for two is always required.
- Enqueue happens only when valid && enq_ready. Requests with valid while enq_ready=0 are ignored; the sources stall.
- Both sources valid in one cycle: mem entry is written at tail, alu at tail+1 (mem is older). One source valid: written at tail.
- A request with reg == 0 is dropped and not enqueued; count is unaffected.
- Dequeue: if count>0, the head entry moves into the wb stage: wb_reg_write=1, wb_reg/wb_data = entry. Otherwise wb_reg_write=0, and wb_reg/wb_data hold their last value.
- count_next = count + enqueued - dequeued.
- flush: count, head and tail all go to 0 next cycle. A same-cycle enqueue is discarded. The wb stage already loaded still completes.
- Bypass: search the wb stage (oldest) plus all valid queue entries. The youngest match wins; a match on index 0 never hits. On a miss, lk_hit=0 and lk_data=0.
- rst=0 (any cycle, including mid-drain): count=0, head=tail=0, all entry valids=0, wb_reg_write=0, wb_reg=0, wb_data=0, enq_ready=1. rst has priority over flush.

## Timing
- Enqueue at edge N into an empty queue gives wb_reg_write=1 in the cycle after edge N+1. Latency is 2 edges to the register file write.
- Throughput: 1 writeback per cycle sustained. Two enqueues per cycle is a burst of at most DEPTH/2 cycles.
- Bypass outputs are combinational from the current state; a request enqueued at edge N is visible to lookups from that edge onward.
- Pointer wrap: tail DEPTH-1 with a dual enqueue writes slots DEPTH-1 and 0.

## Structure
- Shared package mips_pkg holds DATA_W, ADDR_W, REG_ZERO (5'd0), and typedef wb_req_t {reg, data}.
- One sub-module, wbq_match: priority search of DEPTH+1 entries for one index, returning hit/data. It is instantiated twice.

## Test plan
- Reset: hold rst=0 for 2 cycles with both valids high. Expect wb_reg_write=0, enq_ready=1, lk_hit=0, and nothing enqueued.
- Single write: alu_valid with reg 3, data 0x1234. Expect wb_reg_write=1, wb_reg=3, wb_data=0x1234 exactly 2 edges later, then wb_reg_write=0.
- Dual enqueue ordering: mem (reg 5, 0xA) and alu (reg 5, 0xB) in the same cycle. Expect lk_reg_1=5 to give hit with 0xB; writebacks come out 0xA then 0xB on consecutive cycles.
- Full/backpressure: with DEPTH=4, dual-enqueue twice. Expect enq_ready=0 at count 3 and 4; a dropped request is never written back; enq_ready returns to 1 at count 2.
- Reg 0 and flush: alu reg 0 gives no writeback. Enqueue 3 entries, then flush. Only the entry already in the wb stage is written; count=0 next cycle.
- Wrap-around: run 20 random single/dual enqueues with no stalls. Writeback order must match enqueue order and the mem-before-alu rule.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared widths and writeback request type for the register-file write path
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int WBQ_DEPTH = 4;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_queue_if.sv
// regfile_wb_queue_if: writeback requests, register-file write port and bypass lookups
interface regfile_wb_queue_if;
  import mips_pkg::*;
  logic              mem_valid, alu_valid, enq_ready, wb_reg_write;
  logic [ADDR_W-1:0] mem_reg, alu_reg, wb_reg, lk_reg_1, lk_reg_2;
  logic [DATA_W-1:0] mem_data, alu_data, wb_data, lk_data_1, lk_data_2;
  logic              lk_hit_1, lk_hit_2;
  modport master (
    output mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data, lk_reg_1, lk_reg_2,
    input  enq_ready, wb_reg_write, wb_reg, wb_data, lk_hit_1, lk_hit_2, lk_data_1, lk_data_2
  );
  modport slave (
    input  mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data, lk_reg_1, lk_reg_2,
    output enq_ready, wb_reg_write, wb_reg, wb_data, lk_hit_1, lk_hit_2, lk_data_1, lk_data_2
  );
endinterface

// File: rtl/wbq_match.sv
// wbq_match: priority search of pending writebacks for one index; highest slot (youngest) wins
module wbq_match
  import mips_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [ADDR_W-1:0] lk,
  input  logic [N-1:0]      vld,
  input  wb_req_t [N-1:0]   ent,
  output logic              hit,
  output logic [DATA_W-1:0] data
);
  always_comb begin
    hit = 1'b0;
    data = '0;
    for (int i = 0; i < N; i++)
      if (vld[i] && ent[i].rd == lk && lk != REG_ZERO) begin
        hit = 1'b1;
        data = ent[i].data;
      end
  end
endmodule

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: circular writeback FIFO draining one entry per cycle onto the register file
module regfile_wb_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH
) (
  input logic clk,
  input logic rst,
  input logic flush,
  regfile_wb_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0]        head, tail;
  logic [PW:0]          count;
  logic [DEPTH-1:0]     vld;
  wb_req_t              ent [DEPTH];
  wb_req_t              wb;
  logic                 wb_we, mem_en, alu_en, deq;
  logic [1:0]           n_enq;
  wb_req_t [DEPTH:0]    ord;
  logic [DEPTH:0]       ord_v;

  assign q.enq_ready = count <= (PW+1)'(DEPTH - 2);
  assign mem_en = q.mem_valid && q.enq_ready && q.mem_reg != REG_ZERO && !flush;
  assign alu_en = q.alu_valid && q.enq_ready && q.alu_reg != REG_ZERO && !flush;
  assign deq = count != '0 && !flush;
  assign n_enq = {1'b0, mem_en} + {1'b0, alu_en};
  assign q.wb_reg_write = wb_we;
  assign q.wb_reg = wb.rd;
  assign q.wb_data = wb.data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      vld <= '0;
      wb_we <= 1'b0;
      wb <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      vld <= '0;
      wb_we <= 1'b0;
    end else begin
      if (deq) begin
        wb <= ent[head];
        vld[head] <= 1'b0;
        head <= head + 1'b1;
      end
      wb_we <= deq;
      // mem is the older request, so it takes tail and alu lands behind it
      if (mem_en) begin
        ent[tail] <= '{rd: q.mem_reg, data: q.mem_data};
        vld[tail] <= 1'b1;
      end
      if (alu_en) begin
        ent[mem_en ? tail + 1'b1 : tail] <= '{rd: q.alu_reg, data: q.alu_data};
        vld[mem_en ? tail + 1'b1 : tail] <= 1'b1;
      end
      tail <= tail + PW'(n_enq);
      count <= count + (PW+1)'(n_enq) - (PW+1)'(deq);
    end
  end

  // Oldest first: wb stage, then queue slots in age order from head
  always_comb begin
    ord[0] = wb;
    ord_v[0] = wb_we;
    for (int k = 0; k < DEPTH; k++) begin
      ord[k+1] = ent[head + PW'(k)];
      ord_v[k+1] = vld[head + PW'(k)];
    end
  end

  wbq_match #(.N(DEPTH + 1)) u_match_1 (.lk(q.lk_reg_1), .vld(ord_v), .ent(ord), .hit(q.lk_hit_1), .data(q.lk_data_1));
  wbq_match #(.N(DEPTH + 1)) u_match_2 (.lk(q.lk_reg_2), .vld(ord_v), .ent(ord), .hit(q.lk_hit_2), .data(q.lk_data_2));
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: directed checks of reset, ordering, backpressure, flush, bypass and wrap
module tb_regfile_wb_queue;
  import mips_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  int checks = 0;
  int errors = 0;
  wb_req_t exp_q[$];

  regfile_wb_queue_if bus();
  regfile_wb_queue #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .flush(flush), .q(bus.slave));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.mem_valid = 1'b0;
    bus.alu_valid = 1'b0;
  endtask

  task automatic wb_check();
    wb_req_t e;
    if (bus.wb_reg_write) begin
      if (exp_q.size() == 0) chk("wrap_extra_wb", 64'(bus.wb_reg), 64'(0));
      else begin
        e = exp_q.pop_front();
        chk("wrap_order", {bus.wb_reg, bus.wb_data}, {e.rd, e.data});
      end
    end
  endtask

  initial begin
    bus.mem_valid = 1'b1; bus.mem_reg = 5'd7; bus.mem_data = 32'h77;
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd8; bus.alu_data = 32'h88;
    bus.lk_reg_1 = 5'd7; bus.lk_reg_2 = 5'd8;
    step(); step();
    chk("rst_wb_we", 64'(bus.wb_reg_write), 64'(0));
    chk("rst_ready", 64'(bus.enq_ready), 64'(1));
    chk("rst_hit1", 64'(bus.lk_hit_1), 64'(0));
    chk("rst_hit2", 64'(bus.lk_hit_2), 64'(0));
    chk("rst_wb_reg", 64'(bus.wb_reg), 64'(0));
    chk("rst_wb_data", 64'(bus.wb_data), 64'(0));
    idle(); rst = 1'b1;
    step(); step();
    chk("rst_nothing_enq", 64'(bus.wb_reg_write), 64'(0));
    chk("rst_nothing_hit", 64'(bus.lk_hit_1), 64'(0));

    bus.alu_valid = 1'b1; bus.alu_reg = 5'd3; bus.alu_data = 32'h1234; bus.lk_reg_1 = 5'd3;
    step(); idle();
    chk("single_hit", 64'(bus.lk_hit_1), 64'(1));
    chk("single_hit_data", 64'(bus.lk_data_1), 64'h1234);
    chk("single_lat1", 64'(bus.wb_reg_write), 64'(0));
    step();
    chk("single_we", 64'(bus.wb_reg_write), 64'(1));
    chk("single_wb", {bus.wb_reg, bus.wb_data}, {5'd3, 32'h1234});
    chk("single_wbstage_hit", 64'(bus.lk_hit_1), 64'(1));
    step();
    chk("single_we_off", 64'(bus.wb_reg_write), 64'(0));
    chk("single_hold", {bus.wb_reg, bus.wb_data}, {5'd3, 32'h1234});
    chk("single_miss", {bus.lk_hit_1, bus.lk_data_1}, 33'h0);

    bus.mem_valid = 1'b1; bus.mem_reg = 5'd5; bus.mem_data = 32'hA;
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd5; bus.alu_data = 32'hB;
    bus.lk_reg_1 = 5'd5; bus.lk_reg_2 = 5'd0;
    step(); idle();
    chk("dual_hit", {bus.lk_hit_1, bus.lk_data_1}, {1'b1, 32'hB});
    chk("dual_zero_lk", 64'(bus.lk_hit_2), 64'(0));
    step();
    chk("dual_wb0", {bus.wb_reg_write, bus.wb_reg, bus.wb_data}, {1'b1, 5'd5, 32'hA});
    chk("dual_hit_young", 64'(bus.lk_data_1), 64'hB);
    step();
    chk("dual_wb1", {bus.wb_reg_write, bus.wb_reg, bus.wb_data}, {1'b1, 5'd5, 32'hB});
    step();
    chk("dual_done", 64'(bus.wb_reg_write), 64'(0));

    bus.mem_valid = 1'b1; bus.mem_reg = 5'd1; bus.mem_data = 32'h11;
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd2; bus.alu_data = 32'h22;
    step();
    chk("full_ready_c2", 64'(bus.enq_ready), 64'(1));
    bus.mem_reg = 5'd3; bus.mem_data = 32'h33; bus.alu_reg = 5'd4; bus.alu_data = 32'h44;
    step();
    chk("full_ready_c3", 64'(bus.enq_ready), 64'(0));
    chk("full_wb1", {bus.wb_reg_write, bus.wb_reg, bus.wb_data}, {1'b1, 5'd1, 32'h11});
    bus.alu_valid = 1'b0; bus.mem_reg = 5'd9; bus.mem_data = 32'h99; bus.lk_reg_1 = 5'd9; bus.lk_reg_2 = 5'd4;
    step(); idle();
    chk("full_ready_back", 64'(bus.enq_ready), 64'(1));
    chk("full_dropped_hit", 64'(bus.lk_hit_1), 64'(0));
    chk("full_hit4", {bus.lk_hit_2, bus.lk_data_2}, {1'b1, 32'h44});
    chk("full_wb2", {bus.wb_reg_write, bus.wb_reg, bus.wb_data}, {1'b1, 5'd2, 32'h22});
    step();
    chk("full_wb3", {bus.wb_reg_write, bus.wb_reg, bus.wb_data}, {1'b1, 5'd3, 32'h33});
    step();
    chk("full_wb4", {bus.wb_reg_write, bus.wb_reg, bus.wb_data}, {1'b1, 5'd4, 32'h44});
    step();
    chk("full_no_drop_wb", 64'(bus.wb_reg_write), 64'(0));

    bus.alu_valid = 1'b1; bus.alu_reg = 5'd0; bus.alu_data = 32'h55; bus.lk_reg_1 = 5'd0;
    step(); idle();
    chk("zero_hit", 64'(bus.lk_hit_1), 64'(0));
    step();
    chk("zero_no_wb", 64'(bus.wb_reg_write), 64'(0));

    bus.mem_valid = 1'b1; bus.mem_reg = 5'd10; bus.mem_data = 32'h100;
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd11; bus.alu_data = 32'h110;
    step();
    bus.mem_valid = 1'b0; bus.alu_reg = 5'd12; bus.alu_data = 32'h120;
    step(); idle();
    chk("flush_pre_wb", {bus.wb_reg_write, bus.wb_reg, bus.wb_data}, {1'b1, 5'd10, 32'h100});
    flush = 1'b1; bus.mem_valid = 1'b1; bus.mem_reg = 5'd13; bus.mem_data = 32'h130;
    bus.lk_reg_1 = 5'd11; bus.lk_reg_2 = 5'd13;
    step(); flush = 1'b0; idle();
    chk("flush_we", 64'(bus.wb_reg_write), 64'(0));
    chk("flush_hit11", 64'(bus.lk_hit_1), 64'(0));
    chk("flush_hit13", 64'(bus.lk_hit_2), 64'(0));
    chk("flush_ready", 64'(bus.enq_ready), 64'(1));
    step();
    chk("flush_empty", 64'(bus.wb_reg_write), 64'(0));

    for (int t = 0; t < 20; t++) begin
      int guard = 0;
      int kind;
      wb_req_t a, b;
      while (!bus.enq_ready && guard < 8) begin
        step(); wb_check(); guard++;
      end
      kind = int'($urandom_range(0, 2));
      a = '{rd: 5'($urandom_range(1, 31)), data: $urandom};
      b = '{rd: 5'($urandom_range(1, 31)), data: $urandom};
      if (kind != 1) begin
        bus.mem_valid = 1'b1; bus.mem_reg = a.rd; bus.mem_data = a.data;
        exp_q.push_back(a);
      end
      if (kind != 0) begin
        bus.alu_valid = 1'b1; bus.alu_reg = b.rd; bus.alu_data = b.data;
        exp_q.push_back(b);
      end
      step(); idle(); wb_check();
    end
    for (int t = 0; t < 8; t++) begin
      step(); wb_check();
    end
    chk("wrap_drained", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
